// File: rtl/gate_test_sequencer_if.sv
// Signal bundle between the gate test sequencer and the logic around it:
// the start request, the gate stimulus/response and the run results.
interface gate_test_sequencer_if;
  logic       start;
  logic       dut_in_1;
  logic       dut_in_2;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;

  // master: drives start and returns the gate output
  modport master (
    output start, dut_out,
    input  dut_in_1, dut_in_2, busy, done, pass, err_count, fail_mask, vec_idx
  );

  // slave: the sequencer itself
  modport slave (
    input  start, dut_out,
    output dut_in_1, dut_in_2, busy, done, pass, err_count, fail_mask, vec_idx
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Applies vectors 00,01,10,11 to a 2-input gate, waits SETTLE_CYCLES per vector,
// samples the gate output and scores it against the EXPECTED truth table.
module gate_test_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECTED      = 4'b1000
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_test_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_vec;
  logic       r_in_1;
  logic       r_in_2;
  logic       r_pass;
  logic [2:0] r_err;
  logic [3:0] r_mask;

  logic       w_mismatch;
  logic [3:0] w_mask_upd;
  logic [1:0] w_vec_inc;

  assign w_mismatch = (bus.dut_out != EXPECTED[r_vec]);
  assign w_mask_upd = r_mask | ({3'b000, w_mismatch} << r_vec);
  assign w_vec_inc  = r_vec + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_vec   <= 2'd0;
      r_in_1  <= 1'b0;
      r_in_2  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
      r_mask  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_1 <= 1'b0;
          r_in_2 <= 1'b0;
          if (bus.start) begin
            r_state <= S_APPLY;
            r_vec   <= 2'd0;
            r_err   <= 3'd0;
            r_mask  <= 4'd0;
            r_pass  <= 1'b0;
          end
        end
        S_APPLY: begin
          r_cnt   <= SETTLE_LOAD;
          r_state <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (w_mismatch && (r_err != 3'd4)) begin
            r_err <= r_err + 3'd1;
          end
          r_mask <= w_mask_upd;
          if (r_vec == 2'd3) begin
            r_state <= S_DONE;
            r_pass  <= (w_mask_upd == 4'd0);
          end else begin
            // the next vector reaches the gate on the same edge that enters APPLY
            r_vec   <= w_vec_inc;
            r_in_1  <= w_vec_inc[1];
            r_in_2  <= w_vec_inc[0];
            r_state <= S_APPLY;
          end
        end
        S_DONE: begin
          r_in_1  <= 1'b0;
          r_in_2  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_in_1  = r_in_1;
  assign bus.dut_in_2  = r_in_2;
  assign bus.busy      = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_mask = r_mask;
  assign bus.vec_idx   = r_vec;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: default sequencer driving a modelled gate in several fault modes,
// plus a SETTLE_CYCLES=0 instance driving a correct AND gate.
module tb_gate_test_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   checks = 0;
  int   errors = 0;

  gate_test_sequencer_if bus ();
  gate_test_sequencer_if bus0 ();

  gate_test_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(4'b1000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(0), .EXPECTED(4'b1000)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  always #5 clk = ~clk;

  // gate model: 0 AND, 1 stuck-at-0, 2 OR, 3 NAND
  assign bus.dut_out = (mode == 0) ? (bus.dut_in_1 & bus.dut_in_2) :
                       (mode == 1) ? 1'b0 :
                       (mode == 2) ? (bus.dut_in_1 | bus.dut_in_2) :
                                     ~(bus.dut_in_1 & bus.dut_in_2);
  assign bus0.dut_out = bus0.dut_in_1 & bus0.dut_in_2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run(input string tag, input int mode_i, input bit repulse,
                     input logic [2:0] e_err, input logic [3:0] e_mask, input logic e_pass);
    int         done_at;
    logic [7:0] seq;
    mode      = mode_i;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seq       = 8'h00;
    seq[1:0]  = {bus.dut_in_1, bus.dut_in_2};
    done_at   = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (repulse && k == 5) bus.start = 1'b1;
      if (repulse && k == 6) bus.start = 1'b0;
      if ((k % 4 == 0) && (k < 16)) seq[2*(k/4) +: 2] = {bus.dut_in_1, bus.dut_in_2};
      if (bus.done) begin
        done_at = k;
        break;
      end
    end
    check({tag, "_seq"},  {8'h00, seq}, 16'h00E4);
    check({tag, "_done_at"}, 16'(done_at), 16'd16);
    check({tag, "_err"},  {13'd0, bus.err_count}, {13'd0, e_err});
    check({tag, "_mask"}, {12'd0, bus.fail_mask}, {12'd0, e_mask});
    check({tag, "_pass"}, {15'd0, bus.pass}, {15'd0, e_pass});
    @(posedge clk); #1;
    check({tag, "_idle"}, {11'd0, bus.done, bus.busy, bus.dut_in_1, bus.dut_in_2, bus.pass},
          {14'd0, 1'b0, e_pass});
    check({tag, "_vec_hold"}, {14'd0, bus.vec_idx}, 16'd3);
    $display("run %s done_at=%0d err=%0d mask=%b pass=%b", tag, done_at,
             bus.err_count, bus.fail_mask, bus.pass);
  endtask

  initial begin
    int         done0;
    logic [15:0] hold0;
    rst        = 1'b1;
    mode       = 0;
    bus.start  = 1'b0;
    bus0.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    check("rst_dut_in", {14'd0, bus.dut_in_1, bus.dut_in_2}, 16'd0);
    check("rst_results", {8'd0, bus.pass, bus.err_count, bus.fail_mask}, 16'd0);
    check("rst_vec", {14'd0, bus.vec_idx}, 16'd0);

    run("and",  0, 1'b0, 3'd0, 4'b0000, 1'b1);
    run("zero", 1, 1'b0, 3'd1, 4'b1000, 1'b0);
    run("or",   2, 1'b0, 3'd2, 4'b0110, 1'b0);
    run("nand", 3, 1'b0, 3'd4, 4'b1111, 1'b0);
    run("rerun_and", 0, 1'b0, 3'd0, 4'b0000, 1'b1);
    run("repulse", 0, 1'b1, 3'd0, 4'b0000, 1'b1);

    // reset during SETTLE of vector 2 after two NAND mismatches
    mode      = 3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_err", {13'd0, bus.err_count}, 16'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {15'd0, bus.busy}, 16'd0);
    check("midrst_dut_in", {14'd0, bus.dut_in_1, bus.dut_in_2}, 16'd0);
    check("midrst_results", {9'd0, bus.err_count, bus.fail_mask}, 16'd0);
    run("after_rst", 0, 1'b0, 3'd0, 4'b0000, 1'b1);

    // SETTLE_CYCLES=0 instance
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    hold0      = 16'h0000;
    hold0[1:0] = {bus0.dut_in_1, bus0.dut_in_2};
    done0      = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k < 8) hold0[2*k +: 2] = {bus0.dut_in_1, bus0.dut_in_2};
      if (bus0.done) begin
        done0 = k;
        break;
      end
    end
    check("s0_hold", hold0, 16'hFA50);
    check("s0_done_at", 16'(done0), 16'd8);
    check("s0_results", {8'd0, bus0.pass, bus0.err_count, bus0.fail_mask}, 16'h0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
